// File: rtl/csr_file_pkg.sv
// rtl/csr_file_pkg.sv - machine-mode CSR addresses, reset values, write masks and helpers
package csr_file_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;
    localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
    localparam logic [31:0] MTVEC_WMASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFE;
    localparam logic [31:0] MISA_VALUE    = 32'h4000_1100;
    localparam logic [31:0] MHARTID_VALUE = 32'h0000_0000;

    // Addresses that accept writes; everything else drops them.
    function automatic logic csr_writable(input logic [11:0] a);
        case (a)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Value a register holds (and reads back) after being written with d.
    function automatic logic [31:0] csr_view(input logic [11:0] a, input logic [31:0] d);
        case (a)
            CSR_MSTATUS: return (d & MSTATUS_WMASK) | MSTATUS_FIXED;
            CSR_MIE:     return d & MIE_WMASK;
            CSR_MTVEC:   return d & MTVEC_WMASK;
            CSR_MEPC:    return d & MEPC_WMASK;
            default:     return d;
        endcase
    endfunction

    // {hit, masked data} for register a; the interrupt-controller port wins.
    function automatic logic [32:0] csr_sel(input logic [11:0] a,
                                            input logic int_we, input logic [11:0] int_addr,
                                            input logic [31:0] int_data,
                                            input logic ex_we, input logic [11:0] ex_addr,
                                            input logic [31:0] ex_data);
        if (int_we && int_addr == a)
            return {1'b1, csr_view(a, int_data)};
        else if (ex_we && ex_addr == a)
            return {1'b1, csr_view(a, ex_data)};
        else
            return 33'd0;
    endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// rtl/csr_file_counter64.sv - 64-bit counter with per-half writes that suppress the increment
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata_lo,
    input  logic [31:0] wdata_hi,
    output logic [63:0] count
);

    // A write to either half replaces only that half and blocks the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 64'd0;
        end else if (we_lo || we_hi) begin
            if (we_lo) count[31:0]  <= wdata_lo;
            if (we_hi) count[63:32] <= wdata_hi;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR register file with dual write ports and 64-bit counters
module csr_file
    import csr_file_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_we_i,
    input  logic [11:0] ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [11:0] ex_raddr_i,
    output logic [31:0] ex_rdata_o,
    input  logic        int_we_i,
    input  logic [31:0] int_waddr_i,
    input  logic [31:0] int_wdata_i,
    input  logic        instret_i,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mstatus_o,
    output logic        global_int_en_o
);

    logic [11:0] int_addr;
    logic        unused_int_addr_hi;
    logic        ex_we_eff;

    assign int_addr           = int_waddr_i[11:0];
    assign unused_int_addr_hi = ^int_waddr_i[31:12];
    // The execute write is dropped when it collides with an interrupt-controller write.
    assign ex_we_eff = ex_we_i && !(int_we_i && int_addr == ex_waddr_i);

    logic [31:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [63:0] mcycle, minstret;

    logic [32:0] w_mstatus, w_mie, w_mtvec, w_mscratch, w_mepc, w_mcause;
    logic [32:0] w_mcycle, w_mcycleh, w_minstret, w_minstreth;

    assign w_mstatus   = csr_sel(CSR_MSTATUS,   int_we_i, int_addr, int_wdata_i, ex_we_eff, ex_waddr_i, ex_wdata_i);
    assign w_mie       = csr_sel(CSR_MIE,       int_we_i, int_addr, int_wdata_i, ex_we_eff, ex_waddr_i, ex_wdata_i);
    assign w_mtvec     = csr_sel(CSR_MTVEC,     int_we_i, int_addr, int_wdata_i, ex_we_eff, ex_waddr_i, ex_wdata_i);
    assign w_mscratch  = csr_sel(CSR_MSCRATCH,  int_we_i, int_addr, int_wdata_i, ex_we_eff, ex_waddr_i, ex_wdata_i);
    assign w_mepc      = csr_sel(CSR_MEPC,      int_we_i, int_addr, int_wdata_i, ex_we_eff, ex_waddr_i, ex_wdata_i);
    assign w_mcause    = csr_sel(CSR_MCAUSE,    int_we_i, int_addr, int_wdata_i, ex_we_eff, ex_waddr_i, ex_wdata_i);
    assign w_mcycle    = csr_sel(CSR_MCYCLE,    int_we_i, int_addr, int_wdata_i, ex_we_eff, ex_waddr_i, ex_wdata_i);
    assign w_mcycleh   = csr_sel(CSR_MCYCLEH,   int_we_i, int_addr, int_wdata_i, ex_we_eff, ex_waddr_i, ex_wdata_i);
    assign w_minstret  = csr_sel(CSR_MINSTRET,  int_we_i, int_addr, int_wdata_i, ex_we_eff, ex_waddr_i, ex_wdata_i);
    assign w_minstreth = csr_sel(CSR_MINSTRETH, int_we_i, int_addr, int_wdata_i, ex_we_eff, ex_waddr_i, ex_wdata_i);

    // Plain register updates; reset overrides every write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q  <= MSTATUS_RESET;
            mie_q      <= 32'd0;
            mtvec_q    <= 32'd0;
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
        end else begin
            if (w_mstatus[32])  mstatus_q  <= w_mstatus[31:0];
            if (w_mie[32])      mie_q      <= w_mie[31:0];
            if (w_mtvec[32])    mtvec_q    <= w_mtvec[31:0];
            if (w_mscratch[32]) mscratch_q <= w_mscratch[31:0];
            if (w_mepc[32])     mepc_q     <= w_mepc[31:0];
            if (w_mcause[32])   mcause_q   <= w_mcause[31:0];
        end
    end

    csr_counter64 u_mcycle (
        .clk      (clk),
        .rst      (rst),
        .inc      (1'b1),
        .we_lo    (w_mcycle[32]),
        .we_hi    (w_mcycleh[32]),
        .wdata_lo (w_mcycle[31:0]),
        .wdata_hi (w_mcycleh[31:0]),
        .count    (mcycle)
    );

    csr_counter64 u_minstret (
        .clk      (clk),
        .rst      (rst),
        .inc      (instret_i),
        .we_lo    (w_minstret[32]),
        .we_hi    (w_minstreth[32]),
        .wdata_lo (w_minstret[31:0]),
        .wdata_hi (w_minstreth[31:0]),
        .count    (minstret)
    );

    logic [32:0] fwd;
    assign fwd = csr_sel(ex_raddr_i, int_we_i, int_addr, int_wdata_i, ex_we_i, ex_waddr_i, ex_wdata_i);

    // Read mux with same-cycle forwarding of pending writes to writable registers.
    always_comb begin
        ex_rdata_o = 32'd0;
        case (ex_raddr_i)
            CSR_MSTATUS:                 ex_rdata_o = mstatus_q;
            CSR_MISA:                    ex_rdata_o = MISA_VALUE;
            CSR_MIE:                     ex_rdata_o = mie_q;
            CSR_MTVEC:                   ex_rdata_o = mtvec_q;
            CSR_MSCRATCH:                ex_rdata_o = mscratch_q;
            CSR_MEPC:                    ex_rdata_o = mepc_q;
            CSR_MCAUSE:                  ex_rdata_o = mcause_q;
            CSR_MCYCLE,   CSR_CYCLE:     ex_rdata_o = mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:    ex_rdata_o = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:   ex_rdata_o = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: ex_rdata_o = minstret[63:32];
            CSR_MHARTID:                 ex_rdata_o = MHARTID_VALUE;
            default:                     ex_rdata_o = 32'd0;
        endcase
        if (csr_writable(ex_raddr_i) && fwd[32])
            ex_rdata_o = fwd[31:0];
    end

    assign mtvec_o         = mtvec_q;
    assign mepc_o          = mepc_q;
    assign mstatus_o       = mstatus_q;
    assign global_int_en_o = mstatus_q[3];

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - directed self-checking bench for csr_file
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_we_i;
    logic [11:0] ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic [11:0] ex_raddr_i;
    logic [31:0] ex_rdata_o;
    logic        int_we_i;
    logic [31:0] int_waddr_i;
    logic [31:0] int_wdata_i;
    logic        instret_i;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic [31:0] mstatus_o;
    logic        global_int_en_o;

    int errors = 0;
    int checks = 0;

    csr_file dut (
        .clk             (clk),
        .rst             (rst),
        .ex_we_i         (ex_we_i),
        .ex_waddr_i      (ex_waddr_i),
        .ex_wdata_i      (ex_wdata_i),
        .ex_raddr_i      (ex_raddr_i),
        .ex_rdata_o      (ex_rdata_o),
        .int_we_i        (int_we_i),
        .int_waddr_i     (int_waddr_i),
        .int_wdata_i     (int_wdata_i),
        .instret_i       (instret_i),
        .mtvec_o         (mtvec_o),
        .mepc_o          (mepc_o),
        .mstatus_o       (mstatus_o),
        .global_int_en_o (global_int_en_o)
    );

    always #50 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        ex_raddr_i = a;
        #1;
        d = ex_rdata_o;
    endtask

    task automatic idle();
        ex_we_i = 1'b0;
        int_we_i = 1'b0;
        instret_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] addrs [17];
        logic [31:0] exps  [17];
        logic [31:0] d;
        addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80,
                  12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14, 12'h123};
        exps  = '{32'h0000_1800, 32'h4000_1100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        rst = 1'b1;
        idle();
        ex_waddr_i = 12'd0; ex_wdata_i = 32'd0; int_waddr_i = 32'd0; int_wdata_i = 32'd0;
        ex_raddr_i = 12'd0;
        tick(); tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            rd(addrs[i], d);
            checks++;
            if (d !== exps[i]) begin
                errors++;
                $display("FAIL reset_read[%h] got=%h exp=%h", addrs[i], d, exps[i]);
            end
        end
        checks++;
        if (mstatus_o !== 32'h0000_1800 || mtvec_o !== 32'd0 || mepc_o !== 32'd0 || global_int_en_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs mstatus=%h mtvec=%h mepc=%h gie=%b exp=00001800/0/0/0",
                     mstatus_o, mtvec_o, mepc_o, global_int_en_o);
        end
        tick();
        rd(12'hB00, d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL mcycle_first got=%h exp=00000001", d);
        end
    endtask

    task automatic test_trap_sequence();
        logic [31:0] d;
        int_we_i = 1'b1; int_waddr_i = 32'hFFFF_F341; int_wdata_i = 32'h8000_0103;
        tick();
        checks++;
        if (mepc_o !== 32'h8000_0102) begin
            errors++;
            $display("FAIL trap_mepc got=%h exp=80000102", mepc_o);
        end
        int_waddr_i = 32'h0000_0300; int_wdata_i = 32'h0000_1808;
        #1;
        checks++;
        if (global_int_en_o !== 1'b0 || mstatus_o !== 32'h0000_1800) begin
            errors++;
            $display("FAIL trap_mstatus_before gie=%b mstatus=%h exp=0/00001800", global_int_en_o, mstatus_o);
        end
        tick();
        checks++;
        if (global_int_en_o !== 1'b1 || mstatus_o !== 32'h0000_1808) begin
            errors++;
            $display("FAIL trap_mstatus_after gie=%b mstatus=%h exp=1/00001808", global_int_en_o, mstatus_o);
        end
        int_waddr_i = 32'h0000_0342; int_wdata_i = 32'd11;
        tick();
        idle();
        rd(12'h342, d);
        checks++;
        if (d !== 32'd11) begin
            errors++;
            $display("FAIL trap_mcause got=%h exp=0000000b", d);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        int_we_i = 1'b1; int_waddr_i = 32'h0000_0340; int_wdata_i = 32'hAAAA_AAAA;
        ex_we_i = 1'b1; ex_waddr_i = 12'h340; ex_wdata_i = 32'h5555_5555;
        rd(12'h340, d);
        checks++;
        if (d !== 32'hAAAA_AAAA) begin
            errors++;
            $display("FAIL collision_forward got=%h exp=aaaaaaaa", d);
        end
        tick();
        idle();
        rd(12'h340, d);
        checks++;
        if (d !== 32'hAAAA_AAAA) begin
            errors++;
            $display("FAIL collision_result got=%h exp=aaaaaaaa", d);
        end
        // parallel writes to different registers plus masked forwarding of mie
        int_we_i = 1'b1; int_waddr_i = 32'h0000_0342; int_wdata_i = 32'h8000_0007;
        ex_we_i = 1'b1; ex_waddr_i = 12'h304; ex_wdata_i = 32'hFFFF_FFFF;
        rd(12'h304, d);
        checks++;
        if (d !== 32'h0000_0888) begin
            errors++;
            $display("FAIL mie_forward got=%h exp=00000888", d);
        end
        tick();
        idle();
        rd(12'h342, d);
        checks++;
        if (d !== 32'h8000_0007) begin
            errors++;
            $display("FAIL parallel_mcause got=%h exp=80000007", d);
        end
        rd(12'h304, d);
        checks++;
        if (d !== 32'h0000_0888) begin
            errors++;
            $display("FAIL parallel_mie got=%h exp=00000888", d);
        end
    endtask

    task automatic test_counter_wrap(input logic [11:0] lo, input logic [11:0] hi,
                                     input logic [11:0] alias_lo, input logic use_instret);
        logic [31:0] d;
        ex_we_i = 1'b1; ex_waddr_i = lo; ex_wdata_i = 32'hFFFF_FFFE;
        tick();
        ex_waddr_i = hi; ex_wdata_i = 32'd0;
        tick();
        idle();
        rd(lo, d);
        checks++;
        if (d !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL wrap_start[%h] got=%h exp=fffffffe", lo, d);
        end
        instret_i = use_instret;
        tick();
        instret_i = 1'b0;
        rd(hi, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL wrap_mid_hi[%h] got=%h exp=00000000", hi, d);
        end
        instret_i = use_instret;
        tick();
        instret_i = 1'b0;
        rd(lo, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL wrap_lo[%h] got=%h exp=00000000", lo, d);
        end
        rd(hi, d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL wrap_hi[%h] got=%h exp=00000001", hi, d);
        end
        rd(alias_lo, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL wrap_alias[%h] got=%h exp=00000000", alias_lo, d);
        end
    endtask

    task automatic test_read_only();
        logic [31:0] d;
        ex_we_i = 1'b1; ex_waddr_i = 12'h305; ex_wdata_i = 32'hFFFF_FFFF;
        tick();
        ex_waddr_i = 12'h301; ex_wdata_i = 32'h0000_1234;
        tick();
        ex_waddr_i = 12'hF14;
        tick();
        idle();
        rd(12'h305, d);
        checks++;
        if (d !== 32'hFFFF_FFFC || mtvec_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL mtvec_mask got=%h out=%h exp=fffffffc", d, mtvec_o);
        end
        rd(12'h301, d);
        checks++;
        if (d !== 32'h4000_1100) begin
            errors++;
            $display("FAIL misa_ro got=%h exp=40001100", d);
        end
        rd(12'hF14, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL mhartid_ro got=%h exp=00000000", d);
        end
    endtask

    task automatic test_reset_mid_trap();
        logic [31:0] d;
        int_we_i = 1'b1; int_waddr_i = 32'h0000_0341; int_wdata_i = 32'h8000_0200;
        tick();
        int_waddr_i = 32'h0000_0300; int_wdata_i = 32'h0000_1808;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        rd(12'hB00, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rst_mcycle got=%h exp=00000000", d);
        end
        rd(12'h341, d);
        checks++;
        if (d !== 32'd0 || mepc_o !== 32'd0) begin
            errors++;
            $display("FAIL rst_mepc got=%h out=%h exp=00000000", d, mepc_o);
        end
        rd(12'h300, d);
        checks++;
        if (d !== 32'h0000_1800 || mstatus_o !== 32'h0000_1800 || global_int_en_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mstatus got=%h out=%h gie=%b exp=00001800/0", d, mstatus_o, global_int_en_o);
        end
        rd(12'h342, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rst_mcause got=%h exp=00000000", d);
        end
        rd(12'h340, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rst_mscratch got=%h exp=00000000", d);
        end
    endtask

    initial begin
        test_reset();
        test_trap_sequence();
        test_collision();
        test_counter_wrap(12'hB00, 12'hB80, 12'hC00, 1'b0);
        test_counter_wrap(12'hB02, 12'hB82, 12'hC02, 1'b1);
        test_read_only();
        test_reset_mid_trap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
